// File: rtl/fp_mul_seq.sv
// Sequential binary16 multiplier with a shift-add significand loop.
// Each product is written back through a one-cycle register-file write strobe.
module fp_mul_seq #(
  parameter bit SAT_INF = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [3:0]  dest_addr,
  output logic        busy,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [3:0]  count_r;
  logic [21:0] mcand_r;
  logic [21:0] prod_r;
  logic [10:0] mplier_r;
  logic [4:0]  ea_r, eb_r;
  logic        sign_r;
  logic        pend_r;

  // Exponent 0 is flushed to zero and exponent 31 is inf/NaN; both skip the loop.
  function automatic logic is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) ||
           (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
  endfunction

  function automatic logic [15:0] special_result(input logic [15:0] a, input logic [15:0] b);
    logic s, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    za = (a[14:10] == 5'd0);
    zb = (b[14:10] == 5'd0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    if (na || nb || (ia && zb) || (ib && za)) begin
      return 16'h7E00;
    end else if (ia || ib) begin
      return {s, 15'h7C00};
    end else begin
      return {s, 15'h0000};
    end
  endfunction

  function automatic logic [15:0] normalize(input logic [21:0] p, input logic [4:0] ea,
                                            input logic [4:0] eb, input logic s);
    logic signed [6:0] e;
    logic [9:0]        m;
    if (p[21]) begin
      m = p[20:11];
      e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd14;
    end else begin
      m = p[19:10];
      e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
    end
    if (e <= 7'sd0) begin
      return {s, 15'h0000};
    end else if (e >= 7'sd31) begin
      return SAT_INF ? {s, 15'h7C00} : {s, 15'h7BFF};
    end else begin
      return {s, e[4:0], m};
    end
  endfunction

  // State register; busy tracks the state being entered so it is itself a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = is_special(op_a, op_b) ? DONE : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (count_r == 4'd10) begin
          state_s = NORM;
        end else begin
          state_s = MUL;
        end
      end
      NORM:    state_s = DONE;
      DONE: begin
        if (pend_r) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and write-port registers; pend_r delays the special-case strobe by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 16'd0;
      count_r  <= 4'd0;
      mcand_r  <= 22'd0;
      prod_r   <= 22'd0;
      mplier_r <= 11'd0;
      ea_r     <= 5'd0;
      eb_r     <= 5'd0;
      sign_r   <= 1'b0;
      pend_r   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_r   <= op_a[15] ^ op_b[15];
            ea_r     <= op_a[14:10];
            eb_r     <= op_b[14:10];
            wr_addr  <= dest_addr;
            mcand_r  <= {11'd0, 1'b1, op_a[9:0]};
            mplier_r <= {1'b1, op_b[9:0]};
            prod_r   <= 22'd0;
            count_r  <= 4'd0;
            pend_r   <= is_special(op_a, op_b);
            if (is_special(op_a, op_b)) begin
              wr_data <= special_result(op_a, op_b);
            end
          end
        end
        MUL: begin
          if (mplier_r[0]) begin
            prod_r <= prod_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + 4'd1;
        end
        NORM: begin
          wr_data <= normalize(prod_r, ea_r, eb_r, sign_r);
          wr_en   <= (wr_addr != 4'd15);
        end
        DONE: begin
          if (pend_r) begin
            wr_en  <= (wr_addr != 4'd15);
            pend_r <= 1'b0;
          end
        end
        default: begin
          pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed corner cases plus random operands
// compared against an arithmetic binary16 reference model.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;
  logic [3:0]  dest_addr = 4'd0;
  logic        busy, wr_en, busy_s0, wr_en_s0;
  logic [3:0]  wr_addr, wr_addr_s0;
  logic [15:0] wr_data, wr_data_s0;

  int n_cmp = 0;
  int n_err = 0;

  fp_mul_seq #(.SAT_INF(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .dest_addr(dest_addr), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  fp_mul_seq #(.SAT_INF(1'b0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .dest_addr(dest_addr), .busy(busy_s0), .wr_en(wr_en_s0), .wr_addr(wr_addr_s0),
    .wr_data(wr_data_s0)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'd31) || (b[14:10] == 5'd0) || (b[14:10] == 5'd31);
  endfunction

  // Value-level model: decode, multiply real significands, truncate, range-check.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit sat_inf);
    int ea, eb, fa, fb, p, m, e;
    bit s, za, zb, ia, ib, na, nb;
    logic [4:0] e5;
    logic [9:0] m10;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return 16'h7E00;
    if (ia || ib) return {s, 15'h7C00};
    if (za || zb) return {s, 15'h0000};
    p = (1024 + fa) * (1024 + fb);
    if (p >= 2097152) begin
      m = (p / 2048) % 1024; e = ea + eb - 14;
    end else begin
      m = (p / 1024) % 1024; e = ea + eb - 15;
    end
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return sat_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
    e5 = e[4:0]; m10 = m[9:0];
    return {s, e5, m10};
  endfunction

  // One operation; restart_at > 0 re-asserts start with junk operands at edge N+restart_at.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] addr,
                       input int restart_at);
    logic [15:0] exp, exp0;
    int exp_lat, lat, pulses, done_at;
    exp = ref_mul(a, b, 1'b1);
    exp0 = ref_mul(a, b, 1'b0);
    exp_lat = ref_special(a, b) ? 1 : 12;
    lat = 0; pulses = 0; done_at = 0;
    @(negedge clk);
    op_a = a; op_b = b; dest_addr = addr; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); dest_addr = 4'($urandom);
    check_val("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      start = (k == restart_at);
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a = 16'($urandom); op_b = 16'($urandom); dest_addr = 4'($urandom);
      if (wr_en) begin
        if (pulses == 0) begin
          lat = k;
          check_val("wr_data", 32'(wr_data), 32'(exp));
          check_val("wr_addr", 32'(wr_addr), 32'(addr));
          check_val("sat0_data", 32'(wr_data_s0), 32'(exp0));
          check_val("sat0_strobe", {27'd0, wr_en_s0, wr_addr_s0}, {27'd0, 1'b1, addr});
        end
        pulses++;
      end
      if (!busy && done_at == 0) done_at = k;
    end
    if (addr != 4'd15) begin
      check_val("latency", 32'(lat), 32'(exp_lat));
      check_val("pulse_count", 32'(pulses), 32'd1);
    end else begin
      check_val("pc_suppressed", 32'(pulses), 32'd0);
    end
    check_val("busy_drop", 32'(done_at), 32'(exp_lat + 1));
    check_val("sat0_busy", 32'(busy_s0), 32'(busy));
  endtask

  initial begin
    int pulses;
    logic [15:0] ra, rb;
    #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op(16'h3C00, 16'h4000, 4'd3, 0);
    do_op(16'h3E00, 16'h3E00, 4'd1, 0);
    do_op(16'hC000, 16'h0400, 4'd2, 0);
    do_op(16'h7BFF, 16'h4000, 4'd4, 0);
    do_op(16'h0400, 16'h0400, 4'd5, 0);
    do_op(16'h0000, 16'h7C00, 4'd6, 0);
    do_op(16'hBC00, 16'h7C00, 4'd7, 0);
    do_op(16'h7E01, 16'h3C00, 4'd8, 0);
    do_op(16'h3C00, 16'h4000, 4'd9, 4);
    do_op(16'h4200, 16'h4400, 4'd15, 0);
    do_op(16'h0000, 16'h3C00, 4'd15, 0);

    // Reset in the middle of an operation must abort it silently.
    @(negedge clk);
    op_a = 16'h3C00; op_b = 16'h4000; dest_addr = 4'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_wr_en", 32'(wr_en), 32'd0);
    check_val("midrst_wr_data", 32'(wr_data), 32'd0);
    pulses = 0;
    for (int k = 5; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (wr_en) pulses++;
      if (k == 7) begin
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    check_val("midrst_no_pulse", 32'(pulses), 32'd0);
    check_val("midrst_idle", 32'(busy), 32'd0);
    do_op(16'h3C00, 16'h4000, 4'd3, 0);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) begin
        ra[14:10] = 5'($urandom_range(1, 30));
        rb[14:10] = 5'($urandom_range(1, 30));
      end
      do_op(ra, rb, 4'($urandom_range(0, 14)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
